// File: rtl/alu_pkg.sv
// ALU operation encoding shared by the decoder, the sequencer and the datapath.
`timescale 1ns/1ps
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5
    } alu_op_t;

endpackage

// File: rtl/instruction_decoder_pkg.sv
// Instruction encodings, field positions and the sequencer state type.
`timescale 1ns/1ps
package instruction_decoder_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h08,
        OP_SUBI  = 6'h09,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E
    } opcode_t;

    typedef enum logic [5:0] {
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_XOR = 6'h26
    } func_t;

    // Kept outside opcode_t: HALT never reaches the ALU.
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/instruction_decoder.sv
// Maps opcode/func to an ALU operation; ALU_NOP marks an unrecognised instruction.
`timescale 1ns/1ps
module instruction_decoder
    import alu_pkg::*;
    import instruction_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_t     alu_op,
    output logic        alu_b_sel
);

    logic [5:0] opcode;
    logic [5:0] func;
    logic       unused_fields;

    assign opcode        = instr[OPCODE_MSB:OPCODE_LSB];
    assign func          = instr[FUNC_MSB:FUNC_LSB];
    assign unused_fields = ^instr[RS_MSB:FUNC_MSB+1];
    assign alu_b_sel     = (opcode != OP_RTYPE);

    always_comb begin
        alu_op = ALU_NOP;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_XOR:   alu_op = ALU_XOR;
                    default: alu_op = ALU_NOP;
                endcase
            end
            OP_ADDI: alu_op = ALU_ADD;
            OP_SUBI: alu_op = ALU_SUB;
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_XORI: alu_op = ALU_XOR;
            default: alu_op = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller owning PC, IR and the
// register-file write strobe.
`timescale 1ns/1ps
module cpu_sequencer
    import alu_pkg::*;
    import instruction_decoder_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rf_raddr_a,
    output logic [4:0]      rf_raddr_b,
    output logic [4:0]      rf_waddr,
    output logic            rf_we,
    output alu_op_t         alu_op,
    output logic            alu_b_sel,
    output logic [31:0]     imm,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     instr_count
);

    ctrl_state_t     state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [15:0]     count_q, count_d;
    alu_op_t         dec_alu_op;
    logic [5:0]      opcode;

    instruction_decoder u_decoder (
        .instr     (ir_q),
        .alu_op    (dec_alu_op),
        .alu_b_sel (alu_b_sel)
    );

    assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign imem_addr   = pc_q;
    assign instr_count = count_q;
    assign rf_raddr_a  = ir_q[RS_MSB:RS_LSB];
    assign rf_raddr_b  = ir_q[RT_MSB:RT_LSB];
    assign rf_waddr    = (opcode == OP_RTYPE) ? ir_q[RD_MSB:RD_LSB] : ir_q[RT_MSB:RT_LSB];
    assign imm         = {{16{ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
    assign busy        = (state_q == FETCH) || (state_q == DECODE) ||
                         (state_q == EXECUTE) || (state_q == WRITEBACK);
    assign halted      = (state_q == HALTED);
    assign alu_op      = ((state_q == EXECUTE) || (state_q == WRITEBACK)) ? dec_alu_op : ALU_NOP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    // Strobes are decoded from state_q so they fall with an asynchronous reset.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        count_d  = count_q;
        imem_req = 1'b0;
        rf_we    = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    count_d = '0;
                    ir_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = HALTED;
                end else if (dec_alu_op == ALU_NOP) begin
                    illegal = 1'b1;
                    pc_d    = pc_q + PC_W'(4);
                    state_d = FETCH;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: state_d = WRITEBACK;
            WRITEBACK: begin
                rf_we   = 1'b1;
                pc_d    = pc_q + PC_W'(4);
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                state_d = stop ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small instruction-memory responder.
`timescale 1ns/1ps
module tb_cpu_sequencer;
  import alu_pkg::*;
  import instruction_decoder_pkg::*;

  localparam int PC_W = 32;
  localparam logic [31:0] I_ADDI  = 32'h2023_0005;  // addi r3 <- r1 + 5
  localparam logic [31:0] I_ADDIN = 32'h2044_FFFF;  // addi r4 <- r2 + (-1)
  localparam logic [31:0] I_SUB   = 32'h0022_3822;  // sub  r7 <- r1 - r2
  localparam logic [31:0] I_BAD   = 32'h0400_0000;  // opcode 6'h01
  localparam logic [31:0] I_HALT  = 32'hFC00_0000;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [4:0]      rf_raddr_a;
  logic [4:0]      rf_raddr_b;
  logic [4:0]      rf_waddr;
  logic            rf_we;
  alu_op_t         alu_op;
  logic            alu_b_sel;
  logic [31:0]     imm;
  logic            busy;
  logic            halted;
  logic            illegal;
  logic [15:0]     instr_count;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [31:0] mem [0:7];

  cpu_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_waddr    (rf_waddr),
    .rf_we       (rf_we),
    .alu_op      (alu_op),
    .alu_b_sel   (alu_b_sel),
    .imm         (imm),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: acks after ack_delay wait cycles of a held request
  initial begin
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1;
          imem_rdata = mem[imem_addr[4:2]];
          wait_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    int fetch12;
    int ill_cnt;
    int ill_we;
    int we_cnt;
    bit after_ill;
    logic [31:0] after_ill_addr;

    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = I_HALT;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_NOP));
    chk("rst_pc", imem_addr, 0);
    chk("rst_ir", dut.ir_q, 0);
    chk("rst_count", instr_count, 0);

    // ADDI, zero-wait memory, stop held, start pulsed while busy
    mem[0] = I_ADDI;
    stop = 1'b1;
    pulse_start();
    chk("t1_fetch_busy", busy, 1);
    chk("t1_fetch_req", imem_req, 1);
    chk("t1_fetch_addr", imem_addr, 0);
    tick();
    chk("t1_dec_state", 32'(dut.state_q), 32'(DECODE));
    chk("t1_dec_req", imem_req, 0);
    chk("t1_dec_alu_gated", 32'(alu_op), 32'(ALU_NOP));
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_raddr_a", rf_raddr_a, 1);
    chk("t1_imm", imm, 5);
    chk("t1_b_sel", alu_b_sel, 1);
    tick();
    chk("t1_exe_alu", 32'(alu_op), 32'(ALU_ADD));
    chk("t1_exe_we", rf_we, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_wb_we", rf_we, 1);
    chk("t1_wb_state", 32'(dut.state_q), 32'(WRITEBACK));
    chk("t1_wb_alu", 32'(alu_op), 32'(ALU_ADD));
    tick();
    chk("t1_idle_state", 32'(dut.state_q), 32'(IDLE));
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_we", rf_we, 0);
    chk("t1_pc", imem_addr, 4);
    chk("t1_count", instr_count, 1);

    // RTYPE SUB with three wait cycles
    mem[0] = I_SUB;
    ack_delay = 3;
    pulse_start();
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      tick();
    end
    chk("t2_req_cycles", n, 4);
    chk("t2_dec_state", 32'(dut.state_q), 32'(DECODE));
    chk("t2_waddr", rf_waddr, 7);
    chk("t2_raddr_b", rf_raddr_b, 2);
    chk("t2_b_sel", alu_b_sel, 0);
    tick();
    chk("t2_exe_alu", 32'(alu_op), 32'(ALU_SUB));
    tick();
    chk("t2_wb_we", rf_we, 1);
    tick();
    chk("t2_idle_state", 32'(dut.state_q), 32'(IDLE));
    chk("t2_count", instr_count, 1);
    chk("t2_pc", imem_addr, 4);
    ack_delay = 0;
    stop = 1'b0;

    // two legal, one illegal at PC 8, then HALT at PC 12
    mem[0] = I_ADDI;
    mem[1] = I_ADDIN;
    mem[2] = I_BAD;
    mem[3] = I_HALT;
    pulse_start();
    cyc = 0;
    fetch12 = -1;
    ill_cnt = 0;
    ill_we = 0;
    we_cnt = 0;
    after_ill = 1'b0;
    after_ill_addr = '1;
    while (!halted && cyc < 40) begin
      if (illegal) begin
        ill_cnt++;
        if (rf_we) ill_we++;
        after_ill = 1'b1;
      end else if (after_ill && imem_req) begin
        after_ill_addr = imem_addr;
        after_ill = 1'b0;
      end
      if (rf_we) we_cnt++;
      if (rf_we && imem_addr == 32'd4) chk("t3_imm_neg", imm, 32'hFFFF_FFFF);
      if (imem_req && imem_addr == 32'd12 && fetch12 < 0) fetch12 = cyc;
      tick();
      cyc++;
    end
    chk("t3_halted", halted, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ill_pulses", ill_cnt, 1);
    chk("t3_ill_we", ill_we, 0);
    chk("t3_we_pulses", we_cnt, 2);
    chk("t3_fetch_after_ill", after_ill_addr, 12);
    chk("t3_halt_latency", cyc - fetch12, 2);
    chk("t3_pc_at_halt", imem_addr, 12);
    chk("t3_count", instr_count, 2);

    // restart from HALTED
    pulse_start();
    chk("t4_halted", halted, 0);
    chk("t4_busy", busy, 1);
    chk("t4_pc", imem_addr, 0);
    chk("t4_count", instr_count, 0);

    // asynchronous reset in the middle of a fetch
    n = 0;
    while (!rf_we && n < 10) begin
      tick();
      n++;
    end
    chk("t5_wb_seen", rf_we, 1);
    ack_delay = 5;
    tick();
    chk("t5_fetch_req", imem_req, 1);
    chk("t5_fetch_pc", imem_addr, 4);
    chk("t5_fetch_count", instr_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_req", imem_req, 0);
    chk("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_we", rf_we, 0);
    chk("t5_rst_pc", imem_addr, 0);
    chk("t5_rst_count", instr_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_state", 32'(dut.state_q), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
